// File: rtl/react_pkg.sv
// Shared definitions for the multi-channel reaction timer: FSM states and
// default round limits.
package react_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TIMING,
        DONE
    } state_t;

    localparam int DEFAULT_TIMEOUT   = 10000;
    localparam int DEFAULT_MIN_VALID = 100;

endpackage

// File: rtl/react_channel.sv
// One player's lane: rising-edge detection on its button, the latched time,
// the resolved flag and the mutually exclusive hit / false-start / timeout bits.
module react_channel #(
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 10000,
    parameter int MIN_VALID = 100
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             armed,
    input  logic             timing,
    input  logic             timeout_now,
    input  logic [CNT_W-1:0] count,
    input  logic             react,
    output logic [CNT_W-1:0] t_react,
    output logic             hit,
    output logic             false_start,
    output logic             timed_out,
    output logic             resolved,
    output logic             hit_now,
    output logic             resolve_now
);

    logic prev;
    logic react_edge;

    // hit_now and resolve_now let the top arbitrate the winner and detect
    // "all resolved" in the same cycle the result is latched.
    always_comb begin
        react_edge  = react & ~prev;
        hit_now     = timing && !clear && !resolved && react_edge &&
                      (count >= CNT_W'(MIN_VALID));
        resolve_now = timing && !clear && !resolved && (react_edge || timeout_now);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev        <= 1'b0;
            t_react     <= '0;
            hit         <= 1'b0;
            false_start <= 1'b0;
            timed_out   <= 1'b0;
            resolved    <= 1'b0;
        end else begin
            prev <= react;
            if (clear) begin
                t_react     <= '0;
                hit         <= 1'b0;
                false_start <= 1'b0;
                timed_out   <= 1'b0;
                resolved    <= 1'b0;
            end else if (armed && react_edge && !resolved) begin
                false_start <= 1'b1;
                resolved    <= 1'b1;
            end else if (timing && !resolved) begin
                // An edge in the timeout cycle still wins over the timeout.
                if (react_edge) begin
                    t_react <= count;
                    if (count < CNT_W'(MIN_VALID)) begin
                        false_start <= 1'b1;
                    end else begin
                        hit <= 1'b1;
                    end
                    resolved <= 1'b1;
                end else if (timeout_now) begin
                    timed_out <= 1'b1;
                    t_react   <= CNT_W'(TIMEOUT);
                    resolved  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/react_timer_multi.sv
// Multi-player reaction timer: round FSM, shared tick counter and first-hit
// winner arbitration around N_CH react_channel lanes.
module react_timer_multi
    import react_pkg::*;
#(
    parameter  int N_CH      = 4,
    parameter  int CNT_W     = 16,
    parameter  int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter  int MIN_VALID = DEFAULT_MIN_VALID,
    localparam int WIN_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stimulus,
    input  logic [N_CH-1:0]       react,
    output logic [N_CH*CNT_W-1:0] t_react,
    output logic [N_CH-1:0]       hit,
    output logic [N_CH-1:0]       false_start,
    output logic [N_CH-1:0]       timed_out,
    output logic [WIN_W-1:0]      winner,
    output logic                  winner_valid,
    output logic                  busy,
    output logic                  done
);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  count;
    logic              clear;
    logic              abort;
    logic              timeout_now;
    logic              all_resolved;
    logic              enter_done;
    logic [N_CH-1:0]   resolved;
    logic [N_CH-1:0]   hit_now;
    logic [N_CH-1:0]   resolve_now;
    logic [WIN_W-1:0]  first_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ARMED;
            ARMED:   if (stimulus) next_state = TIMING;
            TIMING: begin
                if (!stimulus) begin
                    next_state = IDLE;
                end else if (all_resolved || timeout_now) begin
                    next_state = DONE;
                end
            end
            DONE:    if (start) next_state = ARMED;
            default: next_state = IDLE;
        endcase
    end

    // Arming and aborting both wipe every lane; start in ARMED/TIMING does not.
    always_comb begin
        busy         = (state == ARMED) || (state == TIMING);
        abort        = (state == TIMING) && !stimulus;
        clear        = abort || (start && ((state == IDLE) || (state == DONE)));
        enter_done   = (state == TIMING) && (next_state == DONE);
        timeout_now  = (count == CNT_W'(TIMEOUT));
        all_resolved = &(resolved | resolve_now);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (state != TIMING) begin
            count <= '0;
        end else if (tick && (count != CNT_W'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= enter_done;
        end
    end

    // Scanning downward leaves the lowest-indexed hitting lane as the result.
    always_comb begin
        first_hit = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (hit_now[i]) begin
                first_hit = WIN_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            winner       <= '0;
            winner_valid <= 1'b0;
        end else if ((state == TIMING) && !winner_valid && (|hit_now)) begin
            winner       <= first_hit;
            winner_valid <= 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        react_channel #(
            .CNT_W     (CNT_W),
            .TIMEOUT   (TIMEOUT),
            .MIN_VALID (MIN_VALID)
        ) u_channel (
            .clock       (clock),
            .reset       (reset),
            .clear       (clear),
            .armed       (state == ARMED),
            .timing      (state == TIMING),
            .timeout_now (timeout_now),
            .count       (count),
            .react       (react[i]),
            .t_react     (t_react[i*CNT_W +: CNT_W]),
            .hit         (hit[i]),
            .false_start (false_start[i]),
            .timed_out   (timed_out[i]),
            .resolved    (resolved[i]),
            .hit_now     (hit_now[i]),
            .resolve_now (resolve_now[i])
        );
    end

endmodule

// File: tb/tb_react_timer_multi.sv
// Scoreboard bench for react_timer_multi: each round pushes its expected
// results, and a monitor compares them whenever done pulses.
module tb_react_timer_multi;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  tick;
    logic                  start;
    logic                  stimulus;
    logic [N_CH-1:0]       react;
    logic [N_CH*CNT_W-1:0] t_react;
    logic [N_CH-1:0]       hit;
    logic [N_CH-1:0]       false_start;
    logic [N_CH-1:0]       timed_out;
    logic [1:0]            winner;
    logic                  winner_valid;
    logic                  busy;
    logic                  done;

    react_timer_multi #(
        .N_CH      (N_CH),
        .CNT_W     (CNT_W),
        .TIMEOUT   (10000),
        .MIN_VALID (100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .start        (start),
        .stimulus     (stimulus),
        .react        (react),
        .t_react      (t_react),
        .hit          (hit),
        .false_start  (false_start),
        .timed_out    (timed_out),
        .winner       (winner),
        .winner_valid (winner_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] t;
        logic [3:0]  hit;
        logic [3:0]  fs;
        logic [3:0]  to;
        logic [1:0]  win;
        logic        wv;
    } expect_t;

    expect_t exp_q[$];
    int      check_count = 0;
    int      pass_count  = 0;
    int      done_count  = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] pack_t(input int t0, input int t1,
                                           input int t2, input int t3);
        return {16'(t3), 16'(t2), 16'(t1), 16'(t0)};
    endfunction

    function automatic expect_t make_exp(input logic [63:0] t, input logic [3:0] h,
                                         input logic [3:0] fs, input logic [3:0] to,
                                         input logic [1:0] win, input logic wv);
        expect_t e;
        e.t = t; e.hit = h; e.fs = fs; e.to = to; e.win = win; e.wv = wv;
        return e;
    endfunction

    // Monitor: every done pulse consumes one expected round result.
    always @(negedge clock) begin
        expect_t e;
        if (!reset && done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check_count++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pulse");
            end else begin
                e = exp_q.pop_front();
                checkOutput("round_t_react", t_react, e.t);
                checkOutput("round_hit", 64'(hit), 64'(e.hit));
                checkOutput("round_false_start", 64'(false_start), 64'(e.fs));
                checkOutput("round_timed_out", 64'(timed_out), 64'(e.to));
                checkOutput("round_winner", 64'(winner), 64'(e.win));
                checkOutput("round_winner_valid", 64'(winner_valid), 64'(e.wv));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic begin_timing();
        stimulus = 1'b1;
        @(negedge clock);
    endtask

    task automatic applyStimulus(input int n_ticks, input bit gap);
        repeat (n_ticks) begin
            tick = 1'b1;
            @(negedge clock);
            tick = 1'b0;
            if (gap) @(negedge clock);
        end
    endtask

    task automatic press(input logic [3:0] mask);
        react = react | mask;
        @(negedge clock);
        react = react & ~mask;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, 64'(done), 64'd1);
        @(negedge clock);
    endtask

    task automatic check_cleared(input string name);
        checkOutput({name, "_t_react"}, t_react, 64'd0);
        checkOutput({name, "_results"}, 64'({hit, false_start, timed_out}), 64'd0);
        checkOutput({name, "_winner"}, 64'({winner_valid, winner}), 64'd0);
        checkOutput({name, "_busy_done"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        start    = 1'b0;
        stimulus = 1'b0;
        react    = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_cleared("reset_state");

        // Round 1: ch2 at 250, ch0 at 300, ch1/ch3 time out; ch2 re-press ignored.
        exp_q.push_back(make_exp(pack_t(300, 10000, 250, 10000), 4'b0101, 4'b0000,
                                 4'b1010, 2'd2, 1'b1));
        pulse_start();
        pulse_start();
        checkOutput("armed_busy", 64'(busy), 64'd1);
        begin_timing();
        applyStimulus(250, 1'b0);
        press(4'b0100);
        checkOutput("r1_live_winner", 64'({winner_valid, winner}), 64'({1'b1, 2'd2}));
        applyStimulus(10, 1'b0);
        press(4'b0100);
        applyStimulus(40, 1'b0);
        press(4'b0001);
        applyStimulus(9700, 1'b0);
        wait_done("r1_done");
        checkOutput("r1_idle_busy", 64'(busy), 64'd0);

        // Round 2: ch1 false start in ARMED, ch0 held high at arming, all lanes false start.
        exp_q.push_back(make_exp(pack_t(70, 0, 60, 50), 4'b0000, 4'b1111,
                                 4'b0000, 2'd0, 1'b0));
        react[0] = 1'b1;
        @(negedge clock);
        pulse_start();
        press(4'b0010);
        begin_timing();
        applyStimulus(25, 1'b1);
        applyStimulus(25, 1'b1);
        press(4'b1000);
        applyStimulus(10, 1'b0);
        press(4'b0100);
        react[0] = 1'b0;
        applyStimulus(10, 1'b0);
        press(4'b0001);
        wait_done("r2_done");

        // Round 3: start ignored in TIMING, ch0 at 99, ch1+ch3 tie at 400, ch2 at 401.
        exp_q.push_back(make_exp(pack_t(99, 400, 401, 400), 4'b1110, 4'b0001,
                                 4'b0000, 2'd1, 1'b1));
        pulse_start();
        begin_timing();
        applyStimulus(20, 1'b0);
        pulse_start();
        applyStimulus(79, 1'b0);
        press(4'b0001);
        applyStimulus(301, 1'b0);
        press(4'b1010);
        checkOutput("r3_live_tie_winner", 64'({winner_valid, winner}), 64'({1'b1, 2'd1}));
        applyStimulus(1, 1'b0);
        press(4'b0100);
        wait_done("r3_done");

        // Round 4: stimulus drops at tick 500 -> abort with everything cleared.
        pulse_start();
        begin_timing();
        applyStimulus(150, 1'b0);
        press(4'b0001);
        applyStimulus(350, 1'b0);
        stimulus = 1'b0;
        @(negedge clock);
        check_cleared("abort");
        applyStimulus(3, 1'b0);

        // Round 5: ch2 exactly at MIN_VALID is a hit, then reset at tick 200.
        pulse_start();
        begin_timing();
        applyStimulus(100, 1'b0);
        press(4'b0100);
        checkOutput("r5_live_hit", 64'({hit, false_start}), 64'({4'b0100, 4'b0000}));
        checkOutput("r5_live_t", t_react, pack_t(0, 0, 100, 0));
        applyStimulus(100, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        stimulus = 1'b0;
        check_cleared("mid_reset");

        // Round 6: clean round; ch2 reacts in the very timeout cycle, ch1 times out.
        exp_q.push_back(make_exp(pack_t(120, 10000, 10000, 100), 4'b1101, 4'b0000,
                                 4'b0010, 2'd3, 1'b1));
        pulse_start();
        begin_timing();
        applyStimulus(100, 1'b0);
        press(4'b1000);
        applyStimulus(20, 1'b0);
        press(4'b0001);
        applyStimulus(9880, 1'b0);
        press(4'b0100);
        wait_done("r6_done");
        applyStimulus(5, 1'b0);
        checkOutput("r6_hold_hit", 64'({hit, timed_out}), 64'({4'b1101, 4'b0010}));

        checkOutput("done_pulse_count", 64'(done_count), 64'd4);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/react_timer_multi.md
REACT_TIMER_MULTI -- requirements
Module: react_timer_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent reaction channels (players), 1..8.
REQ-002 Parameter CNT_W, default 16: width of each reaction-time value in ticks.
REQ-003 Parameter TIMEOUT, default 10000: tick count at which a round is forced to end.
REQ-004 Parameter MIN_VALID, default 100: any reaction with fewer ticks than this is an anticipation (false start).
REQ-005 clock  in  1  single clock for all logic.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 tick  in  1  one-cycle time-base enable, 1 ms period.
REQ-008 start  in  1  one-cycle pulse that arms a new round.
REQ-009 stimulus  in  1  level from the random-delay generator; high = stimulus shown.
REQ-010 react  in  N_CH  per-channel reaction buttons, already synchronised and debounced.
REQ-011 t_react  out  N_CH*CNT_W  per-channel latched time; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-012 hit  out  N_CH  channel reacted validly.
REQ-013 false_start  out  N_CH  channel reacted before the stimulus or below MIN_VALID.
REQ-014 timed_out  out  N_CH  channel had not resolved when TIMEOUT was reached.
REQ-015 winner  out  $clog2(N_CH) (minimum 1)  index of the first valid channel.
REQ-016 winner_valid  out  1  winner holds a valid index.
REQ-017 busy  out  1  high in ARMED and TIMING.
REQ-018 done  out  1  one-cycle pulse on entry to DONE.

Function
REQ-019 FSM states and transitions:
- IDLE -> ARMED on start.
- ARMED -> TIMING on stimulus high.
- TIMING -> DONE when all channels are resolved or the counter equals TIMEOUT.
- DONE -> ARMED on start.
- All other transitions are listed in REQ-025 and REQ-026.
REQ-020 Rising-edge detection: edge[i] = react[i] & ~prev[i]; prev is updated every cycle in every state.
REQ-021 ARMED behaviour:
- an edge on channel i sets false_start[i] and marks channel i resolved;
- a level already held high at entry produces no edge.
REQ-022 TIMING counter:
- cleared to 0 on entry;
- increments by 1 per tick;
- saturates at TIMEOUT and never wraps.
REQ-023 TIMING, first edge on an unresolved channel i:
- t_react[i] receives the current counter value;
- if the counter is below MIN_VALID, false_start[i] is set;
- otherwise hit[i] is set;
- channel i is marked resolved;
- later edges on channel i are ignored.
REQ-024 Winner:
- the first cycle that has at least one hit sets winner to the lowest-indexed hitting channel and sets winner_valid;
- winner is frozen for the rest of the round;
- simultaneous hits go to the lowest index.
REQ-025 Timeout: when the counter reaches TIMEOUT, every unresolved channel gets timed_out=1 and t_react=TIMEOUT in the same cycle, and the FSM enters DONE.
REQ-026 Abort: stimulus falling in TIMING returns the FSM to IDLE and clears all results.
REQ-027 start received in ARMED or TIMING is ignored.
REQ-028 In DONE, all results hold until the next start.
REQ-029 Arming: start clears t_react, hit, false_start, timed_out, winner, winner_valid and the resolved flags.
REQ-030 Same-cycle precedence: in the cycle the counter reaches TIMEOUT, an edge is processed first and still counts as a latch, not a timeout.
REQ-031 Result bits are mutually exclusive per channel: exactly one of hit, false_start, timed_out is set once a channel is resolved.

Reset
REQ-032 Reset applies to every register: state=IDLE, counter=0, prev=0, all outputs 0.
REQ-033 Reset asserted mid-round aborts the round with no done pulse.

Structure
REQ-034 A shared package react_pkg holds the FSM state enum (IDLE, ARMED, TIMING, DONE) and the default constants for TIMEOUT and MIN_VALID.
REQ-035 One sub-module, react_channel, is instantiated N_CH times; it owns edge detection, latching, the resolved flag and the three result bits for its channel.
REQ-036 The top level owns the FSM, the shared counter and winner arbitration.

Verification
REQ-037 N_CH=4. start, stimulus high, react[2] edge at tick 250, react[0] edge at tick 300, the rest never react -> t_react[2]=250 and t_react[0]=300, winner=2, timed_out for channels 1 and 3 with t_react=10000, done pulses once.
REQ-038 react[1] edge while ARMED -> false_start[1]=1, hit[1]=0, winner_valid stays 0 when no other channel hits.
REQ-039 react[3] edge at tick 50 (MIN_VALID=100) -> false_start[3]=1 and t_react[3]=50.
REQ-040 react[1] and react[3] edges in the same cycle at tick 400 -> both t_react=400, winner=1.
REQ-041 stimulus drops at tick 500 -> FSM in IDLE, all results 0, no done pulse.
REQ-042 reset asserted at tick 200 -> all outputs 0 on the next cycle; a later start then runs a clean round.
